jreq_encoder: RTL and testbench

//   Inverse of jdecoder: collects N2 request lines into a pending register and

---
 rtl/jreq_encoder_pkg.sv | 25 ++
 rtl/jreq_encoder_if.sv | 35 +++
 rtl/jreq_encoder_pick.sv | 54 +++++
 rtl/jreq_encoder.sv | 75 +++++++
 tb/tb_jreq_encoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/jreq_encoder_pkg.sv
// Shared widths and the issue-stage action type for the request encoder.
// The helper decides what the output stage does on the coming edge.
package jreq_encoder_pkg;

  localparam int JREQ_N  = 2;
  localparam int JREQ_N2 = 1 << JREQ_N;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_DRAIN
  } act_e;

  // A new code may be loaded whenever the offer slot is empty or being accepted now.
  function automatic act_e next_action(input logic valid, input logic ack, input logic any);
    if ((!valid || ack) && any) begin
      return ACT_LOAD;
    end else if (valid && ack) begin
      return ACT_DRAIN;
    end else begin
      return ACT_HOLD;
    end
  endfunction

endpackage

// File: rtl/jreq_encoder_if.sv
// Request-side and consumer-side signals of the request encoder.
// The master drives the request lines and the acknowledge; the slave is the encoder.
interface jreq_encoder_if
  import jreq_encoder_pkg::*;
#(
  parameter int N  = JREQ_N,
  parameter int N2 = JREQ_N2
);

  logic [N2-1:0] breq;
  logic          wack;
  logic [N-1:0]  bos;
  logic          wvalid;
  logic [N2-1:0] bpend;
  logic          wovf;

  modport master (
    output breq,
    output wack,
    input  bos,
    input  wvalid,
    input  bpend,
    input  wovf
  );

  modport slave (
    input  breq,
    input  wack,
    output bos,
    output wvalid,
    output bpend,
    output wovf
  );

endinterface

// File: rtl/jreq_encoder_pick.sv
// Combinational helpers: the round-robin search and the binary-to-onehot decoder.
// The search rotates cand so the slot after ptr sits at bit 0, finds the lowest set bit, then rotates back.
module jrr_pick
  import jreq_encoder_pkg::*;
#(
  parameter int N  = JREQ_N,
  parameter int N2 = JREQ_N2
) (
  input  logic [N2-1:0] bcand,
  input  logic [N-1:0]  bptr,
  output logic [N-1:0]  bsel,
  output logic          wany
);

  logic [N-1:0]    start;
  logic [2*N2-1:0] doubled;
  logic [N2-1:0]   rot;
  logic [N-1:0]    first;

  assign start   = bptr + N'(1);
  assign doubled = {bcand, bcand} >> start;
  assign rot     = doubled[N2-1:0];

  // Scanning downward lets the lowest set bit of the rotated vector win.
  always_comb begin
    first = '0;
    for (int i = N2 - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first = N'(i);
      end
    end
  end

  assign bsel = start + first;
  assign wany = |bcand;

endmodule

module jdecoder
  import jreq_encoder_pkg::*;
#(
  parameter int N  = JREQ_N,
  parameter int N2 = JREQ_N2
) (
  input  logic [N-1:0]  bcode,
  output logic [N2-1:0] bhot
);

  always_comb begin
    bhot        = '0;
    bhot[bcode] = 1'b1;
  end

endmodule

// File: rtl/jreq_encoder.sv
// Round-robin request encoder: collects request lines and offers one binary code at a time.
// Codes are handed to the consumer over a valid/ack handshake with no bubble between codes.
module jreq_encoder
  import jreq_encoder_pkg::*;
#(
  parameter int N  = JREQ_N,
  parameter int N2 = JREQ_N2
) (
  input logic           wclk,
  input logic           wrst,
  jreq_encoder_if.slave bus
);

  logic [N2-1:0] pend_q;
  logic [N-1:0]  bos_q;
  logic [N-1:0]  ptr_q;
  logic          wvalid_q;
  logic          wovf_q;

  logic [N2-1:0] cand;
  logic [N-1:0]  sel;
  logic [N2-1:0] sel_hot;
  logic          any;
  act_e          act;

  assign cand = pend_q | bus.breq;

  jrr_pick #(.N(N), .N2(N2)) u_pick (
    .bcand (cand),
    .bptr  (ptr_q),
    .bsel  (sel),
    .wany  (any)
  );

  jdecoder #(.N(N), .N2(N2)) u_dec (
    .bcode (sel),
    .bhot  (sel_hot)
  );

  assign act = next_action(wvalid_q, bus.wack, any);

  // The code moved to the offer slot leaves pending; a request hitting a pending bit is lost.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      pend_q   <= '0;
      bos_q    <= '0;
      ptr_q    <= N'(N2 - 1);
      wvalid_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wovf_q <= wovf_q | (|(bus.breq & pend_q));
      case (act)
        ACT_LOAD: begin
          pend_q   <= cand & ~sel_hot;
          bos_q    <= sel;
          ptr_q    <= sel;
          wvalid_q <= 1'b1;
        end
        ACT_DRAIN: begin
          pend_q   <= cand;
          wvalid_q <= 1'b0;
        end
        default: begin
          pend_q   <= cand;
        end
      endcase
    end
  end

  assign bus.bos    = bos_q;
  assign bus.wvalid = wvalid_q;
  assign bus.bpend  = pend_q;
  assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_jreq_encoder.sv
// Bench for jreq_encoder: directed request patterns with a scoreboard of expected codes.
// Expected codes are queued as stimulus is driven and popped on every accepted handshake.
module tb_jreq_encoder;

  logic wclk;
  logic wrst;

  int total;
  int bad;
  logic [31:0] sbq[$];

  jreq_encoder_if #(.N(2), .N2(4)) bus ();

  jreq_encoder #(.N(2), .N2(4)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus.slave)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic ack, input int n);
    bus.breq = req;
    bus.wack = ack;
    tick(n);
  endtask

  // Short reset pulse placed between clock edges; outputs must clear with no edge.
  task automatic pulseReset(input string tag);
    wrst = 1'b1;
    #1;
    checkOutput({tag, "_bos"}, {30'd0, bus.bos}, 32'd0);
    checkOutput({tag, "_wvalid"}, {31'd0, bus.wvalid}, 32'd0);
    checkOutput({tag, "_bpend"}, {28'd0, bus.bpend}, 32'd0);
    checkOutput({tag, "_wovf"}, {31'd0, bus.wovf}, 32'd0);
    #1;
    wrst = 1'b0;
    sbq.delete();
  endtask

  task automatic checkState(input string tag, input logic v, input logic [1:0] code,
                            input logic [3:0] pend, input logic ovf);
    checkOutput({tag, "_wvalid"}, {31'd0, bus.wvalid}, {31'd0, v});
    if (v) checkOutput({tag, "_bos"}, {30'd0, bus.bos}, {30'd0, code});
    checkOutput({tag, "_bpend"}, {28'd0, bus.bpend}, {28'd0, pend});
    checkOutput({tag, "_wovf"}, {31'd0, bus.wovf}, {31'd0, ovf});
  endtask

  // Scoreboard: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge wclk) begin
    if (!wrst && bus.wvalid && bus.wack) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected", {30'd0, bus.bos}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("sb_code", {30'd0, bus.bos}, sbq.pop_front());
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    wrst     = 1'b1;
    bus.breq = '0;
    bus.wack = 1'b0;
    #2;
    wrst = 1'b0;
    tick(1);

    // 1: dirty the state, then an asynchronous reset pulse between edges
    applyStimulus(4'b0001, 1'b0, 1);
    applyStimulus(4'b0010, 1'b0, 2);
    checkState("t1_pre", 1'b1, 2'd0, 4'b0010, 1'b1);
    bus.breq = '0;
    pulseReset("t1_rst");

    // 2: single request held on offer for three cycles, then acked
    sbq.push_back(32'd2);
    applyStimulus(4'b0100, 1'b0, 1);
    checkState("t2_e1", 1'b1, 2'd2, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0, 2);
    checkState("t2_e3", 1'b1, 2'd2, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkState("t2_ack", 1'b0, 2'd0, 4'b0000, 1'b0);
    bus.wack = 1'b0;
    checkOutput("t2_drain", sbq.size(), 32'd0);
    pulseReset("t2_rst");

    // 3: ack held, three requests at once -> back-to-back codes 0,1,3
    sbq.push_back(32'd0);
    sbq.push_back(32'd1);
    sbq.push_back(32'd3);
    bus.wack = 1'b1;
    applyStimulus(4'b1011, 1'b1, 1);
    checkState("t3_e1", 1'b1, 2'd0, 4'b1010, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkState("t3_e2", 1'b1, 2'd1, 4'b1000, 1'b0);
    tick(1);
    checkState("t3_e3", 1'b1, 2'd3, 4'b0000, 1'b0);
    tick(1);
    checkState("t3_e4", 1'b0, 2'd0, 4'b0000, 1'b0);
    bus.wack = 1'b0;
    checkOutput("t3_drain", sbq.size(), 32'd0);
    pulseReset("t3_rst");

    // 4: round robin resumes after the last issued code and wraps
    sbq.push_back(32'd1);
    sbq.push_back(32'd3);
    sbq.push_back(32'd0);
    applyStimulus(4'b0010, 1'b0, 1);
    applyStimulus(4'b1001, 1'b0, 1);
    checkState("t4_q", 1'b1, 2'd1, 4'b1001, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkState("t4_a1", 1'b1, 2'd3, 4'b0001, 1'b0);
    tick(2);
    checkState("t4_end", 1'b0, 2'd0, 4'b0000, 1'b0);
    bus.wack = 1'b0;
    checkOutput("t4_drain", sbq.size(), 32'd0);
    pulseReset("t4_rst");

    // 5: repeated request for a pending bit sets the sticky overflow
    sbq.push_back(32'd0);
    sbq.push_back(32'd1);
    applyStimulus(4'b0001, 1'b0, 1);
    applyStimulus(4'b0010, 1'b0, 1);
    checkState("t5_e2", 1'b1, 2'd0, 4'b0010, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1);
    checkState("t5_e3", 1'b1, 2'd0, 4'b0010, 1'b1);
    applyStimulus(4'b0000, 1'b1, 3);
    checkState("t5_end", 1'b0, 2'd0, 4'b0000, 1'b1);
    bus.wack = 1'b0;
    checkOutput("t5_drain", sbq.size(), 32'd0);
    pulseReset("t5_rst");

    // 6: reset lands mid-stream after the first ack, then a fresh request
    sbq.push_back(32'd0);
    applyStimulus(4'b0111, 1'b0, 1);
    applyStimulus(4'b0000, 1'b1, 1);
    checkState("t6_a1", 1'b1, 2'd1, 4'b0100, 1'b0);
    bus.wack = 1'b0;
    checkOutput("t6_drain", sbq.size(), 32'd0);
    pulseReset("t6_rst");
    sbq.push_back(32'd0);
    applyStimulus(4'b0001, 1'b0, 1);
    checkState("t6_fresh", 1'b1, 2'd0, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1);
    bus.wack = 1'b0;
    checkOutput("t6_drain2", sbq.size(), 32'd0);
    pulseReset("t6_rst2");

    // 7: request for the code on offer is queued; a full pending set only flags overflow
    sbq.push_back(32'd0);
    sbq.push_back(32'd1);
    sbq.push_back(32'd2);
    sbq.push_back(32'd3);
    sbq.push_back(32'd0);
    applyStimulus(4'b0001, 1'b0, 1);
    applyStimulus(4'b0001, 1'b0, 1);
    checkState("t7_offer", 1'b1, 2'd0, 4'b0001, 1'b0);
    applyStimulus(4'b1110, 1'b0, 1);
    checkState("t7_full", 1'b1, 2'd0, 4'b1111, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1);
    checkState("t7_ovf", 1'b1, 2'd0, 4'b1111, 1'b1);
    applyStimulus(4'b0000, 1'b1, 6);
    checkState("t7_end", 1'b0, 2'd0, 4'b0000, 1'b1);
    bus.wack = 1'b0;
    checkOutput("t7_drain", sbq.size(), 32'd0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
